onehot_stream_codec: RTL

- Pipelined, handshaked one-hot codec; each transfer selects encode (binary to one-hot) or decode (one-hot to binary) via a per-transfer mode bit.
- Flags non-one-hot or out-of-range inputs and keeps a saturating error count.
- Sits between producers and consumers on valid/ready streams, e.g. arbiter grant vectors feeding index-based datapaths.
- Internal 2-entry skid buffer gives full throughput with registered ready.

---
 rtl/onehot_stream_codec_pkg.sv | 16 +
 rtl/binary_to_onehot.sv | 16 +
 rtl/onehot_validity_check.sv | 23 ++
 rtl/onehot_stream_codec.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/onehot_stream_codec_pkg.sv
// Shared types for the one-hot stream codec: per-transfer mode and the
// occupancy states of the output/skid register pair.
package onehot_stream_codec_pkg;

   typedef enum logic {
      ENCODE = 1'b0,
      DECODE = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/binary_to_onehot.sv
// Binary index to one-hot vector; indices beyond the vector width yield all zeros.
module binary_to_onehot #(
   parameter int WIDTH_BINARY = 8,
   parameter int WIDTH_ONEHOT = 2**WIDTH_BINARY
) (
   input  logic [WIDTH_BINARY-1:0] index,
   output logic [WIDTH_ONEHOT-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < WIDTH_ONEHOT; i++)
         onehot[i] = (index == WIDTH_BINARY'(i));
   end

endmodule

// File: rtl/onehot_validity_check.sv
// Combinational one-hot checker: flags zero / single-bit vectors and reports
// the position of the lowest set bit (0 when the vector is zero).
module onehot_validity_check #(
   parameter int WIDTH_ONEHOT = 256,
   parameter int WIDTH_BINARY = 8
) (
   input  logic [WIDTH_ONEHOT-1:0] vec,
   output logic                    is_onehot,
   output logic                    is_zero,
   output logic [WIDTH_BINARY-1:0] lowest_index
);

   // Scanning downward lets the lowest set bit win.
   always_comb begin
      lowest_index = '0;
      for (int i = WIDTH_ONEHOT-1; i >= 0; i--)
         if (vec[i]) lowest_index = WIDTH_BINARY'(i);
   end

   assign is_zero   = (vec == '0);
   assign is_onehot = !is_zero && ((vec & (vec - WIDTH_ONEHOT'(1))) == '0);

endmodule

// File: rtl/onehot_stream_codec.sv
// Handshaked encode/decode between binary indices and one-hot vectors, with a
// 2-entry output/skid buffer so upstream_ready is a plain register.
module onehot_stream_codec
   import onehot_stream_codec_pkg::*;
#(
   parameter int WIDTH_BINARY      = 8,
   parameter int WIDTH_ONEHOT      = 2**WIDTH_BINARY,
   parameter int ERROR_COUNT_WIDTH = 16
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         upstream_valid,
   output logic                         upstream_ready,
   input  logic                         upstream_mode,
   input  logic [WIDTH_ONEHOT-1:0]      upstream_data,
   output logic                         downstream_valid,
   input  logic                         downstream_ready,
   output logic [WIDTH_ONEHOT-1:0]      downstream_data,
   output logic                         downstream_error,
   output logic [ERROR_COUNT_WIDTH-1:0] error_count,
   input  logic                         clear_errors
);

   mode_e                   mode;
   state_e                  state;
   logic                    ready_q;
   logic [WIDTH_BINARY-1:0] enc_index;
   logic [WIDTH_ONEHOT-1:0] enc_onehot;
   logic                    enc_hi_set;
   logic                    enc_err;
   logic [WIDTH_BINARY-1:0] dec_index;
   logic [WIDTH_ONEHOT-1:0] dec_data;
   logic                    is_onehot;
   logic                    is_zero;
   logic [WIDTH_ONEHOT-1:0] conv_data;
   logic                    conv_err;
   logic [WIDTH_ONEHOT-1:0] out_data, skid_data;
   logic                    out_err, skid_err;
   logic                    accept, drain;

   assign mode = mode_e'(upstream_mode);

   // The binary field and the one-hot field may differ in width either way.
   for (genvar i = 0; i < WIDTH_BINARY; i++) begin : g_enc_idx
      if (i < WIDTH_ONEHOT) begin : g_in
         assign enc_index[i] = upstream_data[i];
      end else begin : g_pad
         assign enc_index[i] = 1'b0;
      end
   end

   if (WIDTH_ONEHOT > WIDTH_BINARY) begin : g_hi
      assign enc_hi_set = |upstream_data[WIDTH_ONEHOT-1:WIDTH_BINARY];
   end else begin : g_no_hi
      assign enc_hi_set = 1'b0;
   end

   assign enc_err = enc_hi_set || (int'(enc_index) >= WIDTH_ONEHOT);

   binary_to_onehot #(
      .WIDTH_BINARY (WIDTH_BINARY),
      .WIDTH_ONEHOT (WIDTH_ONEHOT)
   ) u_enc (
      .index  (enc_index),
      .onehot (enc_onehot)
   );

   onehot_validity_check #(
      .WIDTH_ONEHOT (WIDTH_ONEHOT),
      .WIDTH_BINARY (WIDTH_BINARY)
   ) u_chk (
      .vec          (upstream_data),
      .is_onehot    (is_onehot),
      .is_zero      (is_zero),
      .lowest_index (dec_index)
   );

   for (genvar i = 0; i < WIDTH_ONEHOT; i++) begin : g_dec_data
      if (i < WIDTH_BINARY) begin : g_in
         assign dec_data[i] = dec_index[i];
      end else begin : g_pad
         assign dec_data[i] = 1'b0;
      end
   end

   always_comb begin
      conv_data = '0;
      conv_err  = 1'b0;
      if (mode == DECODE) begin
         conv_data = dec_data;
         conv_err  = is_zero || !is_onehot;
      end else begin
         conv_data = enc_err ? '0 : enc_onehot;
         conv_err  = enc_err;
      end
   end

   assign accept = upstream_valid && ready_q;
   assign drain  = downstream_valid && downstream_ready;

   // ready_q mirrors (state != FULL) one cycle ahead so it leaves a flop directly.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= EMPTY;
         ready_q   <= 1'b1;
         out_data  <= '0;
         out_err   <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
      end else begin
         case (state)
            EMPTY: if (accept) begin
               out_data <= conv_data;
               out_err  <= conv_err;
               state    <= ONE;
            end
            ONE: begin
               if (accept && drain) begin
                  out_data <= conv_data;
                  out_err  <= conv_err;
               end else if (accept) begin
                  skid_data <= conv_data;
                  skid_err  <= conv_err;
                  state     <= FULL;
                  ready_q   <= 1'b0;
               end else if (drain) begin
                  state <= EMPTY;
               end
            end
            FULL: if (drain) begin
               out_data <= skid_data;
               out_err  <= skid_err;
               state    <= ONE;
               ready_q  <= 1'b1;
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         error_count <= '0;
      else if (clear_errors)
         error_count <= (accept && conv_err) ? ERROR_COUNT_WIDTH'(1) : '0;
      else if (accept && conv_err && (error_count != '1))
         error_count <= error_count + ERROR_COUNT_WIDTH'(1);
   end

   assign upstream_ready   = ready_q;
   assign downstream_valid = (state != EMPTY);
   assign downstream_data  = out_data;
   assign downstream_error = out_err;

endmodule
